// File: rtl/capture_ring_ram_pkg.sv
// Shared types and defaults for the capture ring buffer.
// State encoding, default geometry and the pretrigger clamp.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } state_t;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 12;
  localparam int NUM_CH_DEF     = 2;
  localparam int DEPTH          = 2**ADDR_WIDTH_DEF;

  function automatic int clamp_pretrig(
    input int p,
    input int depth = DEPTH
  );
    return (p > depth - 1) ? depth - 1 : p;
  endfunction

endpackage

// File: rtl/capture_ring_ram_if.sv
// Capture/readout bundle for capture_ring_ram.
// master drives arm/sample/trigger/read requests; slave is the buffer.
interface capture_ring_ram_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 2
);
  localparam int W = NUM_CH * DATA_WIDTH;

  logic                  arm;
  logic [ADDR_WIDTH-1:0] pretrig;
  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  trig;
  logic                  busy;
  logic                  waiting;
  logic                  done;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_offset;
  logic                  rd_valid;
  logic [W-1:0]          rd_data;

  modport master (
    output arm, pretrig, in_valid, in_data, trig,
    output rd_en, rd_offset,
    input  busy, waiting, done, trig_addr,
    input  rd_valid, rd_data
  );

  modport slave (
    input  arm, pretrig, in_valid, in_data, trig,
    input  rd_en, rd_offset,
    output busy, waiting, done, trig_addr,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/capture_ring_ram_ram.sv
// sample_ram_2p: 1W/1R synchronous RAM, read-first, array not reset.
// Ports: i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_rdata held.
module sample_ram_2p #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/capture_ring_ram.sv
// Circular multi-channel sample capture with pretrigger and readout.
// Ports: clock, reset_n, bus (capture_ring_ram_if.slave).
module capture_ring_ram
  import capture_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = NUM_CH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  capture_ring_ram_if.slave bus
);
  localparam int RDEPTH = 2**ADDR_WIDTH;
  localparam int W      = NUM_CH * DATA_WIDTH;
  typedef logic [ADDR_WIDTH:0] cnt_t;
  localparam cnt_t C_DEPTH = cnt_t'(RDEPTH);

  state_t                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_pretrig;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  cnt_t                  r_pre_cnt, r_post_cnt;
  logic                  r_pending;
  logic                  w_we, w_fire;
  cnt_t                  w_pre_inc, w_post_inc;
  cnt_t                  w_post_target;
  cnt_t                  w_pre_goal;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_p1, r_rd_valid;

  assign w_pre_inc     = r_pre_cnt + cnt_t'(1);
  assign w_post_inc    = r_post_cnt + cnt_t'(1);
  assign w_pre_goal    = {1'b0, r_pretrig};
  assign w_post_target = C_DEPTH - w_pre_goal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_we      = 1'b0;
    w_fire    = 1'b0;
    if (bus.arm) begin
      w_state_n = FILL;
    end else begin
      unique case (r_state)
        IDLE: ;
        FILL: begin
          w_we = bus.in_valid;
          // pretrig=0 leaves at once; otherwise on the last pre write
          if (r_pre_cnt == w_pre_goal ||
              (bus.in_valid && w_pre_inc == w_pre_goal))
            w_state_n = ARMED;
        end
        ARMED: begin
          w_we = bus.in_valid;
          if (bus.in_valid && (bus.trig || r_pending)) begin
            w_fire    = 1'b1;
            // trigger sample is post sample 1; may already finish
            w_state_n = (w_post_target == cnt_t'(1)) ? DONE : POST;
          end
        end
        POST: begin
          w_we = bus.in_valid;
          if (bus.in_valid && w_post_inc == w_post_target)
            w_state_n = DONE;
        end
        DONE: ;
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_pretrig   <= '0;
      r_trig_addr <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_pending   <= 1'b0;
    end else if (bus.arm) begin
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_pending  <= 1'b0;
      r_pretrig  <= ADDR_WIDTH'(
        clamp_pretrig(int'(bus.pretrig), RDEPTH));
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == FILL && w_we) r_pre_cnt <= w_pre_inc;
      if (r_state == ARMED)
        r_pending <= w_fire ? 1'b0 : (r_pending | bus.trig);
      if (w_fire) begin
        r_trig_addr <= r_wr_ptr;
        r_post_cnt  <= cnt_t'(1);
      end else if (r_state == POST && w_we) begin
        r_post_cnt <= w_post_inc;
      end
    end
  end

  // offset 0 is the oldest pretrigger sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr  <= '0;
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_addr  <= r_trig_addr - r_pretrig + bus.rd_offset;
      r_rd_p1    <= bus.rd_en;
      r_rd_valid <= r_rd_p1;
    end
  end

  sample_ram_2p #(
    .AW(ADDR_WIDTH),
    .DW(W)
  ) u_ram (
    .i_clk  (clock),
    .i_rst_n(reset_n),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.in_data),
    .i_re   (r_rd_p1),
    .i_raddr(r_rd_addr),
    .o_rdata(bus.rd_data)
  );

  assign bus.busy      = (r_state == FILL) || (r_state == ARMED) ||
                         (r_state == POST);
  assign bus.waiting   = (r_state == ARMED);
  assign bus.done      = (r_state == DONE);
  assign bus.trig_addr = r_trig_addr;
  assign bus.rd_valid  = r_rd_valid;
endmodule
